// File: rtl/tdm_demux4.sv
// Time-division 1:4 demultiplexer: tracks frame alignment (HUNT/LOCK) on a
// SYNC-flagged word stream and steers each word into one of four held outputs.
module tdm_demux4 #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  input  logic             SYNC,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2,
  output logic [WIDTH-1:0] Q3,
  output logic             V0,
  output logic             V1,
  output logic             V2,
  output logic             V3,
  output logic             FRAME_DONE,
  output logic             LOCKED,
  output logic             SYNC_ERR
);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] q_q [4];
  logic [WIDTH-1:0] q_d [4];
  logic [3:0]       v_q, v_d;
  logic             frame_done_q, frame_done_d;
  logic             sync_err_q, sync_err_d;

  always_comb begin
    // NOTE: every signal gets a default up front so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d      = state_q;
    slot_d       = slot_q;
    q_d          = q_q;
    v_d          = '0;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;

    if (DIN_VALID) begin
      unique case (state_q)
        HUNT: begin
          if (SYNC) begin
            q_d[0]  = DIN;
            v_d[0]  = 1'b1;
            slot_d  = 2'd1;
            state_d = LOCK;
          end
        end
        LOCK: begin
          if (SYNC) begin
            // A SYNC anywhere but slot 0 realigns on this word.
            sync_err_d = (slot_q != 2'd0);
            q_d[0]     = DIN;
            v_d[0]     = 1'b1;
            slot_d     = 2'd1;
          end else if (slot_q == 2'd0) begin
            sync_err_d = 1'b1;
            slot_d     = 2'd0;
            state_d    = HUNT;
          end else begin
            q_d[slot_q]  = DIN;
            v_d[slot_q]  = 1'b1;
            frame_done_d = (slot_q == 2'd3);
            slot_d       = slot_q + 2'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (RST) begin
      state_q      <= HUNT;
      slot_q       <= 2'd0;
      v_q          <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      for (int i = 0; i < 4; i++) q_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      v_q          <= v_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
      for (int i = 0; i < 4; i++) q_q[i] <= q_d[i];
    end
  end

  assign Q0         = q_q[0];
  assign Q1         = q_q[1];
  assign Q2         = q_q[2];
  assign Q3         = q_q[3];
  assign V0         = v_q[0];
  assign V1         = v_q[1];
  assign V2         = v_q[2];
  assign V3         = v_q[3];
  assign FRAME_DONE = frame_done_q;
  assign LOCKED     = (state_q == LOCK);
  assign SYNC_ERR   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed scenarios plus random traffic,
// all compared against a frame-level reference model.
module tb_tdm_demux4;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [W-1:0] DIN = '0;
  logic         DIN_VALID = 1'b0;
  logic         SYNC = 1'b0;
  logic [W-1:0] Q0, Q1, Q2, Q3;
  logic         V0, V1, V2, V3, FRAME_DONE, LOCKED, SYNC_ERR;

  int total = 0;
  int bad   = 0;

  tdm_demux4 #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .DIN_VALID(DIN_VALID), .SYNC(SYNC),
    .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3),
    .V0(V0), .V1(V1), .V2(V2), .V3(V3),
    .FRAME_DONE(FRAME_DONE), .LOCKED(LOCKED), .SYNC_ERR(SYNC_ERR)
  );

  always #5 CLK = ~CLK;

  // Reference model: channel memory, alignment flag and expected position.
  logic [W-1:0] m_q [4];
  logic [3:0]   m_v;
  logic         m_fd, m_locked, m_se;
  int           m_slot;

  wire [4*W+6:0] obs = {Q0, Q1, Q2, Q3, V3, V2, V1, V0, FRAME_DONE, LOCKED, SYNC_ERR};
  wire [3:0]     vv  = {V3, V2, V1, V0};

  function automatic logic [4*W+6:0] expv();
    return {m_q[0], m_q[1], m_q[2], m_q[3], m_v, m_fd, m_locked, m_se};
  endfunction

  task automatic model_apply(input logic rst, input logic valid, input logic sync,
                             input logic [W-1:0] din);
    m_v = '0; m_fd = 1'b0; m_se = 1'b0;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_q[i] = '0;
      m_locked = 1'b0;
      m_slot   = 0;
    end else if (valid) begin
      if (sync) begin
        if (m_locked && m_slot != 0) m_se = 1'b1;
        m_q[0] = din; m_v[0] = 1'b1; m_slot = 1; m_locked = 1'b1;
      end else if (m_locked) begin
        if (m_slot == 0) begin
          m_se = 1'b1; m_locked = 1'b0;
        end else begin
          m_q[m_slot] = din; m_v[m_slot] = 1'b1;
          m_fd   = (m_slot == 3);
          m_slot = (m_slot + 1) % 4;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic rst, input logic valid, input logic sync,
                      input logic [W-1:0] din);
    RST = rst; DIN_VALID = valid; SYNC = sync; DIN = din;
    model_apply(rst, valid, sync, din);
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      if (i < 2) step(1'b1, 1'b1, 1'b1, 8'hFF);
      else       step(1'b0, 1'b0, 1'b0, 8'h00);
      total++;
      if (obs !== '0) begin
        bad++;
        $display("FAIL reset[%0d] got=%h want=0", i, obs);
      end
    end
  endtask

  task automatic test_nominal();
    logic [W-1:0] w;
    for (int i = 0; i < 4; i++) begin
      w = 8'h10 + W'(i);
      step(1'b0, 1'b1, (i == 0), w);
      total++;
      if (vv !== (4'b1 << i) || FRAME_DONE !== (i == 3) || LOCKED !== 1'b1 || SYNC_ERR !== 1'b0) begin
        bad++;
        $display("FAIL nominal_pulse[%0d] got v=%b fd=%b lk=%b se=%b want v=%b fd=%b lk=1 se=0",
                 i, vv, FRAME_DONE, LOCKED, SYNC_ERR, 4'b1 << i, (i == 3));
      end
    end
    total++;
    if ({Q0, Q1, Q2, Q3} !== 32'h10111213) begin
      bad++;
      $display("FAIL nominal_q got=%h want=10111213", {Q0, Q1, Q2, Q3});
    end
  endtask

  task automatic test_gapped();
    int fd_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, (i == 0), 8'h10 + W'(i));
      fd_cnt += int'(FRAME_DONE);
      total++;
      if (vv !== (4'b1 << i)) begin
        bad++;
        $display("FAIL gap_word[%0d] got v=%b want v=%b", i, vv, 4'b1 << i);
      end
      if (i < 3) begin
        for (int g = 0; g < 3; g++) begin
          step(1'b0, 1'b0, 1'b1, 8'hEE);
          fd_cnt += int'(FRAME_DONE);
          total++;
          if ({vv, FRAME_DONE, SYNC_ERR} !== 6'b0 || obs !== expv()) begin
            bad++;
            $display("FAIL gap_idle[%0d.%0d] got=%h want=%h", i, g, obs, expv());
          end
        end
      end
    end
    total++;
    if ({Q0, Q1, Q2, Q3} !== 32'h10111213 || fd_cnt != 1) begin
      bad++;
      $display("FAIL gap_result got q=%h fd_cnt=%0d want q=10111213 fd_cnt=1",
               {Q0, Q1, Q2, Q3}, fd_cnt);
    end
  endtask

  task automatic test_early_sync();
    int fd_cnt = 0;
    step(1'b0, 1'b1, 1'b1, 8'hA0);
    step(1'b0, 1'b1, 1'b0, 8'hA1);
    fd_cnt += int'(FRAME_DONE);
    step(1'b0, 1'b1, 1'b1, 8'hB0);
    total++;
    if (SYNC_ERR !== 1'b1 || vv !== 4'b0001 || Q0 !== 8'hB0 || LOCKED !== 1'b1 || FRAME_DONE !== 1'b0) begin
      bad++;
      $display("FAIL early_sync got se=%b v=%b q0=%h lk=%b fd=%b want se=1 v=0001 q0=b0 lk=1 fd=0",
               SYNC_ERR, vv, Q0, LOCKED, FRAME_DONE);
    end
    for (int i = 1; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'hB0 + W'(i));
      fd_cnt += int'(FRAME_DONE);
    end
    total++;
    if ({Q1, Q2, Q3} !== 24'hB1B2B3 || fd_cnt != 1 || FRAME_DONE !== 1'b1) begin
      bad++;
      $display("FAIL early_sync_frame got q=%h fd_cnt=%0d want q=b1b2b3 fd_cnt=1", {Q1, Q2, Q3}, fd_cnt);
    end
  endtask

  task automatic test_missing_sync();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, (i == 0), 8'hC0 + W'(i));
    step(1'b0, 1'b1, 1'b0, 8'h55);
    total++;
    if (SYNC_ERR !== 1'b1 || LOCKED !== 1'b0 || Q0 !== 8'hC0 || vv !== 4'b0) begin
      bad++;
      $display("FAIL missing_sync got se=%b lk=%b q0=%h v=%b want se=1 lk=0 q0=c0 v=0000",
               SYNC_ERR, LOCKED, Q0, vv);
    end
    step(1'b0, 1'b1, 1'b0, 8'h66);
    total++;
    if (obs !== expv() || LOCKED !== 1'b0 || vv !== 4'b0 || SYNC_ERR !== 1'b0) begin
      bad++;
      $display("FAIL hunt_ignore got=%h want=%h", obs, expv());
    end
    step(1'b0, 1'b1, 1'b1, 8'h77);
    total++;
    if (Q0 !== 8'h77 || LOCKED !== 1'b1 || vv !== 4'b0001 || SYNC_ERR !== 1'b0) begin
      bad++;
      $display("FAIL relock got q0=%h lk=%b v=%b se=%b want q0=77 lk=1 v=0001 se=0",
               Q0, LOCKED, vv, SYNC_ERR);
    end
  endtask

  task automatic test_reset_mid_frame();
    step(1'b0, 1'b1, 1'b1, 8'h21);
    step(1'b0, 1'b1, 1'b0, 8'h22);
    step(1'b1, 1'b1, 1'b0, 8'h23);
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL mid_reset got=%h want=0", obs);
    end
    step(1'b0, 1'b1, 1'b0, 8'h33);
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL mid_reset_ignore got=%h want=0", obs);
    end
    step(1'b0, 1'b1, 1'b1, 8'h44);
    total++;
    if (Q0 !== 8'h44 || LOCKED !== 1'b1 || vv !== 4'b0001) begin
      bad++;
      $display("FAIL mid_reset_relock got q0=%h lk=%b v=%b want q0=44 lk=1 v=0001", Q0, LOCKED, vv);
    end
  endtask

  task automatic test_random();
    logic rst, valid, sync;
    for (int n = 0; n < 600; n++) begin
      rst   = ($urandom_range(0, 99) == 0);
      valid = ($urandom_range(0, 9) < 7);
      // Mostly well-formed framing with occasional stray or missing SYNC.
      sync  = ($urandom_range(0, 9) == 0) ? ~(m_slot == 0) : (m_slot == 0);
      step(rst, valid, sync, W'($urandom));
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL random[%0d] got=%h want=%h", n, obs, expv());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_q[i] = '0;
    m_v = '0; m_fd = 1'b0; m_locked = 1'b0; m_se = 1'b0; m_slot = 0;
    @(posedge CLK); #1;
    test_reset();
    test_nominal();
    test_gapped();
    test_early_sync();
    test_missing_sync();
    test_reset_mid_frame();
    step(1'b1, 1'b0, 1'b0, 8'h00);
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receiver-side counterpart to the team's 4:1 select mux: a time-division 1:4 demultiplexer.
- Accepts a framed serial word stream (slot 0..3, slot 0 flagged by SYNC), tracks frame alignment with a small FSM and slot counter, and steers each word into one of four registered channel outputs with per-channel update strobes.
- Sits at the far end of a 4-channel TDM link, downstream of the link deserializer.

Parameters:
- WIDTH, 8, data word width in bits (min 1).

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST  input  1  reset, synchronous, active-high.
- DIN  input  WIDTH  incoming TDM data word.
- DIN_VALID  input  1  DIN/SYNC qualify this cycle; no backpressure.
- SYNC  input  1  DIN is slot 0 of a frame; ignored when DIN_VALID=0.
- Q0, Q1, Q2, Q3  output  WIDTH each  held channel data, slots 0..3.
- V0, V1, V2, V3  output  1 each  one-cycle pulse: matching Qn updated this cycle.
- FRAME_DONE  output  1  one-cycle pulse when slot 3 is written; coincident with V3.
- LOCKED  output  1  high while FSM is in LOCK.
- SYNC_ERR  output  1  one-cycle pulse on any alignment violation.

Behaviour:
- Clock and reset: one clock (CLK). Reset RST is synchronous, active-high.
- Reset values: Q0..Q3=0, V0..V3=0, FRAME_DONE=0, LOCKED=0, SYNC_ERR=0. Slot counter=0, FSM=HUNT.
- RST has priority over all other inputs in the same cycle. Reset mid-frame discards the partial frame and returns to HUNT.
- All outputs are registered. Latency is 1 cycle: a word accepted on edge k appears on Qn, with its Vn pulse, after edge k.
- Pulses: V*, FRAME_DONE and SYNC_ERR are high for exactly one cycle per event and default to 0 every cycle.
- Q hold: Qn holds its value until its next write. Only one Vn may be high in any cycle.
- Cycles with DIN_VALID=0 change no state except clearing pulses. Gaps of any length between valid words are allowed.
- 2-bit slot counter: increments on each accepted word and wraps 3->0.
- FSM state HUNT (LOCKED=0):
  - DIN_VALID=1, SYNC=0: word discarded, no pulses.
  - DIN_VALID=1, SYNC=1: write Q0, pulse V0, slot<=1, go LOCK.
- FSM state LOCK (LOCKED=1), on DIN_VALID=1:
  - SYNC=0 and slot!=0: write Q[slot], pulse V[slot], slot<=slot+1 (mod 4). At slot 3 also pulse FRAME_DONE.
  - SYNC=1 and slot==0: normal slot-0 write (V0), slot<=1.
  - SYNC=1 and slot!=0 (early sync): pulse SYNC_ERR, write word to Q0, pulse V0, slot<=1, stay LOCK (realign). No FRAME_DONE for the truncated frame.
  - SYNC=0 and slot==0 (missing sync): pulse SYNC_ERR, discard word, slot<=0, go HUNT. LOCKED drops in the same cycle as the pulse.
- LOCKED deasserts only via the missing-sync case or RST.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: assert RST for 2 cycles with DIN=8'hFF, DIN_VALID=1, SYNC=1 -> all Q=0, all V=0, LOCKED=0, SYNC_ERR=0 during and 1 cycle after reset.
- Nominal frame: from HUNT, send valid words 8'h10(SYNC),8'h11,8'h12,8'h13 back-to-back:
  - V0..V3 pulse on consecutive cycles, each 1 cycle after its input.
  - Q0..Q3 = 10,11,12,13.
  - FRAME_DONE pulses with V3.
  - LOCKED rises with V0.
- Gapped input: same frame with 3 idle cycles (DIN_VALID=0) between words -> identical Q values; no pulses during gaps; FRAME_DONE only once.
- Early sync: lock, send 8'hA0(SYNC),8'hA1, then 8'hB0(SYNC),8'hB1,8'hB2,8'hB3:
  - SYNC_ERR pulses with V0 for B0; Q0=B0, LOCKED stays 1.
  - No FRAME_DONE for the A-frame; FRAME_DONE for the B-frame; final Q1..Q3=B1,B2,B3.
- Missing sync: complete a frame, then send 8'h55 with SYNC=0:
  - SYNC_ERR pulses and LOCKED=0; Q0 unchanged, no V pulse.
  - Subsequent 8'h66 (SYNC=0) is ignored; 8'h77 (SYNC=1) relocks with Q0=77.
- Reset mid-frame: after slots 0,1 written with 8'h21,8'h22, assert RST 1 cycle -> all Q=0, LOCKED=0. Next valid 8'h33 (SYNC=0) ignored; 8'h44 (SYNC=1) lands in Q0.
